// File: rtl/io_host_master_if.sv
// io_host_master_if: byte-serial handshake between the host master
// and its responder (codes plus one data byte each way).
interface io_host_master_if;
  logic [1:0] to_hw_sig;
  logic [7:0] to_hw_port;
  logic [1:0] to_sw_sig;
  logic [7:0] to_sw_port;

  modport master (
    output to_hw_sig,
    output to_hw_port,
    input  to_sw_sig,
    input  to_sw_port
  );

  modport slave (
    input  to_hw_sig,
    input  to_hw_port,
    output to_sw_sig,
    output to_sw_port
  );
endinterface

// File: rtl/io_host_master.sv
// io_host_master: sends 32 operand bytes, requests a compute, then
// reads back a 16-byte result, aborting any wait that exceeds TIMEOUT.
module io_host_master #(
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [127:0]     msg_in,
  input  logic [127:0]     key_in,
  output logic [127:0]     msg_out,
  output logic             busy,
  output logic             done,
  output logic             error,
  io_host_master_if.master hs
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEND_A = 3'd1;
  localparam logic [2:0] S_SEND_R = 3'd2;
  localparam logic [2:0] S_COMP   = 3'd3;
  localparam logic [2:0] S_RREQ   = 3'd4;
  localparam logic [2:0] S_RREL   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  localparam logic [15:0] WMAX = 16'(TIMEOUT - 1);

  logic [2:0]   state;
  logic [255:0] tx;
  logic [127:0] rx;
  logic [5:0]   cnt;
  logic [15:0]  wait_cnt;
  logic         go;
  logic         waiting;
  logic         tmo;

  always_comb begin
    go            = 1'b0;
    waiting       = 1'b0;
    hs.to_hw_sig  = 2'b00;
    unique case (state)
      S_SEND_A: begin
        waiting      = 1'b1;
        go           = hs.to_sw_sig == 2'b01;
        hs.to_hw_sig = 2'b01;
      end
      S_SEND_R: begin
        waiting = 1'b1;
        go      = hs.to_sw_sig == 2'b00;
      end
      S_COMP: begin
        waiting      = 1'b1;
        go           = hs.to_sw_sig == 2'b11;
        hs.to_hw_sig = 2'b10;
      end
      S_RREQ: begin
        waiting      = 1'b1;
        go           = hs.to_sw_sig == 2'b10;
        hs.to_hw_sig = 2'b11;
      end
      S_RREL: begin
        waiting = 1'b1;
        go      = hs.to_sw_sig == 2'b00;
      end
      default: ;
    endcase
  end

  // a matching responder code in the final cycle still wins
  assign tmo = waiting && !go && (wait_cnt == WMAX);

  // the send register shifts left, so the current byte is always on top
  assign hs.to_hw_port = (state == S_SEND_A || state == S_SEND_R)
                       ? tx[255:248] : 8'h00;

  assign busy = state != S_IDLE;
  assign done = state == S_DONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      tx       <= '0;
      rx       <= '0;
      cnt      <= '0;
      wait_cnt <= '0;
      msg_out  <= '0;
      error    <= 1'b0;
    end else begin
      wait_cnt <= (waiting && !go && !tmo) ? wait_cnt + 16'd1 : 16'd0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            tx    <= {msg_in, key_in};
            error <= 1'b0;
            cnt   <= '0;
            state <= S_SEND_A;
          end
        end
        S_SEND_A: begin
          if (go) state <= S_SEND_R;
        end
        S_SEND_R: begin
          if (go) begin
            if (cnt == 6'd31) begin
              cnt   <= '0;
              state <= S_COMP;
            end else begin
              cnt   <= cnt + 6'd1;
              tx    <= {tx[247:0], 8'h00};
              state <= S_SEND_A;
            end
          end
        end
        S_COMP: begin
          if (go) state <= S_RREQ;
        end
        S_RREQ: begin
          if (go) begin
            rx    <= {rx[119:0], hs.to_sw_port};
            state <= S_RREL;
          end
        end
        S_RREL: begin
          if (go) begin
            if (cnt == 6'd15) begin
              cnt   <= '0;
              state <= S_DONE;
            end else begin
              cnt   <= cnt + 6'd1;
              state <= S_RREQ;
            end
          end
        end
        S_DONE: begin
          msg_out <= rx;
          state   <= S_IDLE;
        end
        S_ERR: begin
          state <= S_IDLE;
        end
      endcase
      if (tmo) begin
        state <= S_ERR;
        error <= 1'b1;
      end
    end
  end

endmodule

// File: doc/io_host_master.md
IO_HOST_MASTER -- requirements
Module: io_host_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024: wait-state cycle limit before abort (legal range 2..65535).
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port start  in  1  request one transaction; sampled only in IDLE.
REQ-005 SHALL have ports msg_in and key_in  in  128 each  message and key, captured on an accepted start.
REQ-006 SHALL have port msg_out  out  128  last successfully received 16-byte result.
REQ-007 SHALL have ports busy, done, error  out  1 each  active / one-cycle completion pulse / sticky abort flag.
REQ-008 SHALL have ports to_hw_sig  out  2 and to_hw_port  out  8  host-side handshake code and data byte.
REQ-009 SHALL have ports to_sw_sig  in  2 and to_sw_port  in  8  responder handshake code and data byte; same clock domain, no synchronizer.

Function
REQ-010 SHALL drive the host end of the byte-serial handshake: host codes 00 idle, 01 byte valid, 10 compute request, 11 byte request; responder codes 00 idle, 01 byte accepted, 10 byte valid, 11 result ready.
REQ-011 SHALL implement states IDLE, SEND_ASSERT, SEND_RELEASE, COMPUTE, RECV_REQ, RECV_RELEASE, DONE, ERROR.
REQ-012 IDLE: to_hw_sig=00, busy=0; start=1 latches msg_in/key_in into a 256-bit send register {msg_in,key_in}, clears error, zeroes the byte counter and enters SEND_ASSERT next cycle.
REQ-013 SEND_ASSERT: to_hw_sig=01, to_hw_port=send-register byte[counter], bits 255:248 first (msg_in MSB byte first, key_in last); to_sw_sig==01 -> SEND_RELEASE.
REQ-014 SEND_RELEASE: to_hw_sig=00, to_hw_port holds the same byte; to_sw_sig==00 -> counter+1, then SEND_ASSERT if 32 bytes are not yet sent, else COMPUTE with counter cleared.
REQ-015 COMPUTE: to_hw_sig=10; to_sw_sig==11 -> RECV_REQ.
REQ-016 RECV_REQ: to_hw_sig=11; to_sw_sig==10 -> capture to_sw_port into receive shift register (first byte lands in bits 127:120) and go to RECV_RELEASE.
REQ-017 RECV_RELEASE: to_hw_sig=00; to_sw_sig==00 -> counter+1, then RECV_REQ if 16 bytes are not yet received, else DONE.
REQ-018 DONE: done=1 for exactly one cycle, msg_out<=receive register in that cycle, then IDLE; msg_out SHALL change only here or on reset.
REQ-019 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored and SHALL NOT alter the latched operands.
REQ-020 A wait counter SHALL clear on every state change and increment each cycle spent in SEND_ASSERT/SEND_RELEASE/COMPUTE/RECV_REQ/RECV_RELEASE; reaching TIMEOUT-1 without the exit condition -> ERROR.
REQ-021 ERROR: to_hw_sig=00, error set (sticky until next accepted start), msg_out unchanged, done=0, then IDLE next cycle.
REQ-022 The exit condition SHALL take priority over timeout in the same cycle; unexpected responder codes SHALL be ignored (continue waiting).
REQ-023 Byte counter SHALL be 6 bits and SHALL never wrap within a transaction; transfer lengths are fixed at 32 bytes out and 16 in.
REQ-024 to_hw_port SHALL be 00 in IDLE, COMPUTE, RECV_*, DONE and ERROR.

Reset
REQ-025 reset=1 SHALL force IDLE in the next cycle from any state, including mid-transfer, with to_hw_sig=00, to_hw_port=00, busy=0, done=0, error=0, msg_out=0, all counters 0.
REQ-026 reset SHALL take priority over start and over every handshake condition.

Verification
REQ-027 Responder model acks each code one cycle after it appears; msg_in=0x00112233_44556677_8899AABB_CCDDEEFF, key_in=0x000102..0F, model returns 0x69C4E0D8_6A7B0430_D8CDB780_70B4C55A -> bytes out in order 00,11,..FF,00,01,..0F; done pulses once; msg_out equals returned value; error=0.
REQ-028 Responder never answers SEND_ASSERT, TIMEOUT=16 -> ERROR entered after 16 cycles in SEND_ASSERT, error=1, msg_out retains prior value, IDLE next cycle; next start clears error.
REQ-029 reset asserted during RECV_REQ on byte 7 -> next cycle IDLE with all outputs zero; fresh transaction then completes normally.
REQ-030 start held high through an entire transaction while msg_in changes each cycle -> only the value present at the accepting cycle is transmitted; a second transaction starts only after DONE returns to IDLE.
REQ-031 Responder exits each wait exactly at the TIMEOUT-1 count -> no ERROR, transaction completes (exit beats timeout).
REQ-032 Responder injects code 11 during SEND_ASSERT and 01 during RECV_REQ -> ignored, states unchanged until the correct code arrives.
